// File: rtl/unidad_de_control_multiciclo.sv
// unidad_de_control_multiciclo: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control unit.
// Define UC_INTERRUPCION_EN to add the Interrupcion/Atendiendo interrupt entry state.
module unidad_de_control_multiciclo #(
   parameter int W_OP  = 7,
   parameter int W_REG = 3,
   parameter int W_FUN = 4,
   localparam int W_INSTR = W_OP + 3*W_REG
) (
   input  logic               Reloj,
   input  logic               Reiniciar,
   input  logic [W_INSTR-1:0] Instruccion,
   input  logic               Bandera,
   input  logic               MemListo,
`ifdef UC_INTERRUPCION_EN
   input  logic               Interrupcion,
   output logic               Atendiendo,
`endif
   output logic               MemLeer,
   output logic               MemEscribir,
   output logic               SelectDR,
   output logic               LoadDR,
   output logic               SelectAR,
   output logic               LoadAR,
   output logic [1:0]         SelectPC,
   output logic               LoadPC,
   output logic               LoadIR,
   output logic               LoadCR,
   output logic               WriteSelect,
   output logic               WriteEnable,
   output logic [W_REG-1:0]   WriteAddress,
   output logic [W_REG-1:0]   ReadAddressA,
   output logic [W_REG-1:0]   ReadAddressB,
   output logic [W_FUN-1:0]   Fun,
   output logic [2:0]         Estado,
   output logic               Ilegal,
   output logic               Detenido
);
   typedef enum logic [2:0] {
      INICIO     = 3'd0,
      BUSCA      = 3'd1,
      DECODIFICA = 3'd2,
      EJECUTA    = 3'd3,
      MEMORIA    = 3'd4,
      ESCRIBE    = 3'd5,
      ALTO       = 3'd6,
      INTERRUMPE = 3'd7
   } estado_t;
   estado_t estado_q, estado_d;
   logic ilegal_q, ilegal_d;
   logic [W_OP-1:0] op;
   logic [W_REG-1:0] rd, rf1, rf2;
   logic es_nop, es_alu, es_load, es_store, es_jump, es_branch, es_halt, es_ilegal, es_mem, irq;
   assign {op, rd, rf1, rf2} = Instruccion;
   assign es_nop    = op == '0;
   assign es_alu    = !es_nop && op < W_OP'(16);
   assign es_load   = op == W_OP'(16);
   assign es_store  = op == W_OP'(17);
   assign es_jump   = op == W_OP'(32);
   assign es_branch = op == W_OP'(33);
   assign es_halt   = op == '1;
   assign es_mem    = es_load | es_store;
   assign es_ilegal = !(es_nop | es_alu | es_mem | es_jump | es_branch | es_halt);
`ifdef UC_INTERRUPCION_EN
   assign irq = Interrupcion;
`else
   assign irq = 1'b0;
`endif
   always_ff @(posedge Reloj) begin
      if (!Reiniciar) begin
         estado_q <= INICIO;
         ilegal_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         ilegal_q <= ilegal_d;
      end
   end
   // Instructions that finish in EJECUTA or ESCRIBE may divert to the interrupt state.
   always_comb begin
      estado_d = estado_q;
      ilegal_d = ilegal_q;
      case (estado_q)
         INICIO:     estado_d = BUSCA;
         BUSCA:      estado_d = MemListo ? DECODIFICA : BUSCA;
         DECODIFICA: estado_d = EJECUTA;
         EJECUTA: begin
            ilegal_d = ilegal_q | es_ilegal;
            estado_d = es_halt ? ALTO : es_alu ? ESCRIBE : es_mem ? MEMORIA : irq ? INTERRUMPE : BUSCA;
         end
         MEMORIA:    estado_d = !MemListo ? MEMORIA : es_load ? ESCRIBE : BUSCA;
         ESCRIBE:    estado_d = irq ? INTERRUMPE : BUSCA;
         ALTO:       estado_d = ALTO;
         default:    estado_d = BUSCA;
      endcase
   end
   always_comb begin
      MemLeer      = 1'b0;
      MemEscribir  = 1'b0;
      SelectDR     = 1'b0;
      LoadDR       = 1'b0;
      SelectAR     = 1'b0;
      LoadAR       = 1'b0;
      SelectPC     = 2'd0;
      LoadPC       = 1'b0;
      LoadIR       = 1'b0;
      LoadCR       = 1'b0;
      WriteSelect  = 1'b0;
      WriteEnable  = 1'b0;
      WriteAddress = '0;
      ReadAddressA = '0;
      ReadAddressB = '0;
      Fun          = '0;
`ifdef UC_INTERRUPCION_EN
      Atendiendo   = 1'b0;
`endif
      case (estado_q)
         BUSCA: begin
            MemLeer = 1'b1;
            LoadIR  = MemListo;
            LoadPC  = MemListo;
         end
         DECODIFICA: begin
            ReadAddressA = rf1;
            ReadAddressB = rf2;
         end
         EJECUTA: begin
            ReadAddressA = rf1;
            ReadAddressB = rf2;
            LoadCR       = es_alu;
            LoadDR       = es_alu | es_store;
            LoadAR       = es_mem;
            SelectAR     = es_mem;
            Fun          = es_alu ? op[W_FUN-1:0] : '0;
            LoadPC       = es_jump | (es_branch & Bandera);
            SelectPC     = es_jump ? 2'd2 : (es_branch & Bandera) ? 2'd1 : 2'd0;
         end
         // DR keeps loading from memory until the read completes, so no MemListo path is needed.
         MEMORIA: begin
            ReadAddressA = rf1;
            ReadAddressB = rf2;
            MemLeer      = es_load;
            MemEscribir  = es_store;
            LoadDR       = es_load;
            SelectDR     = es_load;
         end
         ESCRIBE: begin
            ReadAddressA = rf1;
            ReadAddressB = rf2;
            WriteEnable  = 1'b1;
            WriteAddress = rd;
            WriteSelect  = es_load;
         end
`ifdef UC_INTERRUPCION_EN
         INTERRUMPE: begin
            LoadPC       = 1'b1;
            SelectPC     = 2'd2;
            ReadAddressA = '1;
            Atendiendo   = 1'b1;
         end
`endif
         default: ;
      endcase
   end
   assign Estado   = estado_q;
   assign Ilegal   = ilegal_q;
   assign Detenido = estado_q == ALTO;
endmodule

// File: tb/tb_unidad_de_control_multiciclo.sv
// tb_unidad_de_control_multiciclo: directed vector table plus hand sequences for the control unit.
module tb_unidad_de_control_multiciclo;
   logic        Reloj = 1'b0;
   logic        Reiniciar = 1'b0;
   logic [15:0] Instruccion = 16'h0;
   logic        Bandera = 1'b0;
   logic        MemListo = 1'b0;
   logic        MemLeer, MemEscribir, SelectDR, LoadDR, SelectAR, LoadAR;
   logic [1:0]  SelectPC;
   logic        LoadPC, LoadIR, LoadCR, WriteSelect, WriteEnable;
   logic [2:0]  WriteAddress, ReadAddressA, ReadAddressB;
   logic [3:0]  Fun;
   logic [2:0]  Estado;
   logic        Ilegal, Detenido;
   int total = 0;
   int bad = 0;
   localparam logic [15:0] I_ALU = 16'h060A, I_LD = 16'h20E5, I_ST = 16'h2253, I_BR = 16'h4237;
   localparam logic [15:0] I_JMP = 16'h4028, I_ILL = 16'hAA00, I_HLT = 16'hFE00, I_NOP = 16'h0000;
   typedef struct {
      string       nm;
      logic        rn;
      logic [15:0] ins;
      logic        bf;
      logic        ml;
      logic [2:0]  est;
      logic [1:0]  mem;
      logic [4:0]  ld;
      logic [4:0]  sel;
      logic        we;
      logic [2:0]  wa;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [3:0]  fun;
      logic [1:0]  flg;
   } vec_t;
   vec_t tab[$];
   unidad_de_control_multiciclo dut (
      .Reloj(Reloj), .Reiniciar(Reiniciar), .Instruccion(Instruccion), .Bandera(Bandera),
      .MemListo(MemListo), .MemLeer(MemLeer), .MemEscribir(MemEscribir),
      .SelectDR(SelectDR), .LoadDR(LoadDR), .SelectAR(SelectAR), .LoadAR(LoadAR),
      .SelectPC(SelectPC), .LoadPC(LoadPC), .LoadIR(LoadIR), .LoadCR(LoadCR),
      .WriteSelect(WriteSelect), .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
      .ReadAddressA(ReadAddressA), .ReadAddressB(ReadAddressB), .Fun(Fun),
      .Estado(Estado), .Ilegal(Ilegal), .Detenido(Detenido)
   );
   always #5 Reloj = ~Reloj;
   // ld = {IR,PC,DR,AR,CR}, sel = {SelectPC,SelectDR,SelectAR,WriteSelect}, mem = {Leer,Escribir}, flg = {Ilegal,Detenido}
   function automatic void add(input string nm, input logic rn, input logic [15:0] ins, input logic bf,
                               input logic ml, input logic [2:0] est, input logic [1:0] mem,
                               input logic [4:0] ld, input logic [4:0] sel, input logic we,
                               input logic [2:0] wa, input logic [2:0] ra, input logic [2:0] rb,
                               input logic [3:0] fun, input logic [1:0] flg);
      tab.push_back(vec_t'{nm, rn, ins, bf, ml, est, mem, ld, sel, we, wa, ra, rb, fun, flg});
   endfunction
   task automatic run(input vec_t e);
      logic [30:0] got, want;
      Reiniciar = e.rn;
      Instruccion = e.ins;
      Bandera = e.bf;
      MemListo = e.ml;
      #1;
      got = {Estado, MemLeer, MemEscribir, LoadIR, LoadPC, LoadDR, LoadAR, LoadCR, SelectPC, SelectDR,
             SelectAR, WriteSelect, WriteEnable, WriteAddress, ReadAddressA, ReadAddressB, Fun, Ilegal, Detenido};
      want = {e.est, e.mem, e.ld, e.sel, e.we, e.wa, e.ra, e.rb, e.fun, e.flg};
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%b want=%b", e.nm, got, want);
      end
      @(posedge Reloj);
      #1;
   endtask
   initial begin
      int split;
      add("rst0",       1'b0, I_NOP, 1'b0, 1'b0, 3'd0, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("rst1",       1'b0, I_NOP, 1'b0, 1'b0, 3'd0, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("inicio",     1'b1, I_NOP, 1'b0, 1'b0, 3'd0, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("busca_wait", 1'b1, I_ALU, 1'b0, 1'b0, 3'd1, 2'b10, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("alu_busca",  1'b1, I_ALU, 1'b0, 1'b1, 3'd1, 2'b10, 5'b11000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("alu_dec",    1'b1, I_ALU, 1'b0, 1'b0, 3'd2, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd1, 3'd2, 4'd0, 2'b00);
      add("alu_ex",     1'b1, I_ALU, 1'b0, 1'b0, 3'd3, 2'b00, 5'b00101, 5'b00000, 1'b0, 3'd0, 3'd1, 3'd2, 4'd3, 2'b00);
      add("alu_wb",     1'b1, I_ALU, 1'b0, 1'b0, 3'd5, 2'b00, 5'b00000, 5'b00000, 1'b1, 3'd0, 3'd1, 3'd2, 4'd0, 2'b00);
      add("ld_busca",   1'b1, I_LD,  1'b0, 1'b1, 3'd1, 2'b10, 5'b11000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("ld_dec",     1'b1, I_LD,  1'b0, 1'b0, 3'd2, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd4, 3'd5, 4'd0, 2'b00);
      add("ld_ex",      1'b1, I_LD,  1'b0, 1'b0, 3'd3, 2'b00, 5'b00010, 5'b00010, 1'b0, 3'd0, 3'd4, 3'd5, 4'd0, 2'b00);
      split = tab.size();
      add("ld_mem",     1'b1, I_LD,  1'b0, 1'b1, 3'd4, 2'b10, 5'b00100, 5'b00100, 1'b0, 3'd0, 3'd4, 3'd5, 4'd0, 2'b00);
      add("ld_wb",      1'b1, I_LD,  1'b0, 1'b0, 3'd5, 2'b00, 5'b00000, 5'b00001, 1'b1, 3'd3, 3'd4, 3'd5, 4'd0, 2'b00);
      add("br1_busca",  1'b1, I_BR,  1'b0, 1'b1, 3'd1, 2'b10, 5'b11000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("br1_dec",    1'b1, I_BR,  1'b0, 1'b0, 3'd2, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd6, 3'd7, 4'd0, 2'b00);
      add("br1_ex",     1'b1, I_BR,  1'b1, 1'b0, 3'd3, 2'b00, 5'b01000, 5'b01000, 1'b0, 3'd0, 3'd6, 3'd7, 4'd0, 2'b00);
      add("br0_busca",  1'b1, I_BR,  1'b0, 1'b1, 3'd1, 2'b10, 5'b11000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("br0_dec",    1'b1, I_BR,  1'b0, 1'b0, 3'd2, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd6, 3'd7, 4'd0, 2'b00);
      add("br0_ex",     1'b1, I_BR,  1'b0, 1'b0, 3'd3, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd6, 3'd7, 4'd0, 2'b00);
      add("jmp_busca",  1'b1, I_JMP, 1'b0, 1'b1, 3'd1, 2'b10, 5'b11000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("jmp_dec",    1'b1, I_JMP, 1'b0, 1'b0, 3'd2, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd5, 3'd0, 4'd0, 2'b00);
      add("jmp_ex",     1'b1, I_JMP, 1'b0, 1'b0, 3'd3, 2'b00, 5'b01000, 5'b10000, 1'b0, 3'd0, 3'd5, 3'd0, 4'd0, 2'b00);
      add("il_busca",   1'b1, I_ILL, 1'b0, 1'b1, 3'd1, 2'b10, 5'b11000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("il_dec",     1'b1, I_ILL, 1'b0, 1'b0, 3'd2, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("il_ex",      1'b1, I_ILL, 1'b0, 1'b0, 3'd3, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("nop_busca",  1'b1, I_NOP, 1'b0, 1'b1, 3'd1, 2'b10, 5'b11000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b10);
      add("nop_dec",    1'b1, I_NOP, 1'b0, 1'b0, 3'd2, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b10);
      add("nop_ex",     1'b1, I_NOP, 1'b0, 1'b0, 3'd3, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b10);
      add("st_busca",   1'b1, I_ST,  1'b0, 1'b1, 3'd1, 2'b10, 5'b11000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b10);
      add("st_dec",     1'b1, I_ST,  1'b0, 1'b0, 3'd2, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd2, 3'd3, 4'd0, 2'b10);
      add("st_ex",      1'b1, I_ST,  1'b0, 1'b0, 3'd3, 2'b00, 5'b00110, 5'b00010, 1'b0, 3'd0, 3'd2, 3'd3, 4'd0, 2'b10);
      add("st_mem",     1'b1, I_ST,  1'b0, 1'b0, 3'd4, 2'b01, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd2, 3'd3, 4'd0, 2'b10);
      add("st_mem_rst", 1'b0, I_ST,  1'b0, 1'b0, 3'd4, 2'b01, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd2, 3'd3, 4'd0, 2'b10);
      add("rst_idle",   1'b1, I_ST,  1'b0, 1'b0, 3'd0, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("h_busca",    1'b1, I_HLT, 1'b0, 1'b1, 3'd1, 2'b10, 5'b11000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("h_dec",      1'b1, I_HLT, 1'b0, 1'b0, 3'd2, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("h_ex",       1'b1, I_HLT, 1'b0, 1'b0, 3'd3, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      add("alto1",      1'b1, I_HLT, 1'b0, 1'b0, 3'd6, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b01);
      add("alto2",      1'b1, I_HLT, 1'b1, 1'b1, 3'd6, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b01);
      add("alto_rst",   1'b0, I_HLT, 1'b0, 1'b0, 3'd6, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b01);
      add("post_rst",   1'b1, I_NOP, 1'b0, 1'b0, 3'd0, 2'b00, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 2'b00);
      @(posedge Reloj);
      #1;
      for (int i = 0; i < split; i++) run(tab[i]);
      // LOAD waits three cycles in MEMORIA with the read request held.
      for (int i = 0; i < 3; i++) begin
         MemListo = 1'b0;
         #1;
         total++;
         if (Estado !== 3'd4 || MemLeer !== 1'b1 || MemEscribir !== 1'b0) begin
            bad++;
            $display("FAIL ld_wait%0d est=%0d leer=%b esc=%b want est=4 leer=1 esc=0", i, Estado, MemLeer, MemEscribir);
         end
         @(posedge Reloj);
         #1;
      end
      for (int i = split; i < tab.size(); i++) run(tab[i]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
